// File: rtl/ahb_gpio_pkg.sv
// rtl/ahb_gpio_pkg.sv - shared AHB encodings and GPIO bank register map
package ahb_gpio_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_WORD = 3'b010;

    // Byte offsets of the registers inside one bank window
    localparam logic [4:0] OFF_OUT  = 5'h00;
    localparam logic [4:0] OFF_OEB  = 5'h04;
    localparam logic [4:0] OFF_IN   = 5'h08;
    localparam logic [4:0] OFF_IEN  = 5'h0C;
    localparam logic [4:0] OFF_RISE = 5'h10;
    localparam logic [4:0] OFF_FALL = 5'h14;
    localparam logic [4:0] OFF_STAT = 5'h18;
    localparam logic [4:0] OFF_RSVD = 5'h1C;

    localparam int BANK_STRIDE = 32'h20;

endpackage

// File: rtl/ahb_gpio_bank_ctrl_core.sv
// rtl/ahb_gpio_bank_ctrl_core.sv - one GPIO bank: registers, synchroniser, edge detect, irq
//   clk, rst_n       : clock, asynchronous active-low reset
//   pin_in           : raw pad inputs of this bank
//   edge_en          : 0 while edge detection is blanked after reset
//   wr_en/wr_off/wr_data : qualified word write from the bus data phase
//   rd_off/rd_data   : combinational register read
//   pin_out/pin_oeb  : pad output value / active-low enable
//   irq              : registered |(STAT & IEN)
module gpio_bank_core
    import ahb_gpio_pkg::*;
#(
    parameter int BANK_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [BANK_W-1:0] pin_in,
    input  logic              edge_en,
    input  logic              wr_en,
    input  logic [4:0]        wr_off,
    input  logic [BANK_W-1:0] wr_data,
    input  logic [4:0]        rd_off,
    output logic [BANK_W-1:0] rd_data,
    output logic [BANK_W-1:0] pin_out,
    output logic [BANK_W-1:0] pin_oeb,
    output logic              irq
);

    logic [BANK_W-1:0] sync_q [SYNC_STAGES];
    logic [BANK_W-1:0] prev_q, out_q, oeb_q, ien_q, rise_q, fall_q, stat_q;
    logic [BANK_W-1:0] pin_sync, stat_set, stat_clr;

    assign pin_sync = sync_q[SYNC_STAGES-1];
    assign stat_set = edge_en ? ((pin_sync & ~prev_q & rise_q) | (~pin_sync & prev_q & fall_q))
                              : '0;
    assign stat_clr = (wr_en && wr_off == OFF_STAT) ? wr_data : '0;
    assign pin_out  = out_q;
    assign pin_oeb  = oeb_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            prev_q <= '0;
            out_q  <= '0;
            oeb_q  <= '1;
            ien_q  <= '0;
            rise_q <= '0;
            fall_q <= '0;
            stat_q <= '0;
            irq    <= 1'b0;
        end else begin
            sync_q[0] <= pin_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            prev_q <= pin_sync;
            if (wr_en) begin
                case (wr_off)
                    OFF_OUT:  out_q  <= wr_data;
                    OFF_OEB:  oeb_q  <= wr_data;
                    OFF_IEN:  ien_q  <= wr_data;
                    OFF_RISE: rise_q <= wr_data;
                    OFF_FALL: fall_q <= wr_data;
                    default:  ;
                endcase
            end
            // A new edge in the same cycle as a W1C keeps the bit set
            stat_q <= (stat_q & ~stat_clr) | stat_set;
            irq    <= |(stat_q & ien_q);
        end
    end

    always_comb begin
        rd_data = '0;
        case (rd_off)
            OFF_OUT:  rd_data = out_q;
            OFF_OEB:  rd_data = oeb_q;
            OFF_IN:   rd_data = pin_sync;
            OFF_IEN:  rd_data = ien_q;
            OFF_RISE: rd_data = rise_q;
            OFF_FALL: rd_data = fall_q;
            OFF_STAT: rd_data = stat_q;
            OFF_RSVD: rd_data = '0;
            default:  rd_data = '0;
        endcase
    end

endmodule

// File: rtl/ahb_gpio_bank_ctrl.sv
// rtl/ahb_gpio_bank_ctrl.sv - zero-wait AHB-Lite slave owning NBANKS GPIO banks
//   HCLK, HRESETn    : clock, asynchronous active-low reset
//   HSEL..HREADY     : AHB-Lite address/data phase inputs
//   HREADYOUT, HRDATA: always ready, combinational read data in the data phase
//   gpio_in/out/oeb  : pad pins, bank b at [b*BANK_W +: BANK_W]
//   user_irq         : bit b = bank b interrupt, bits >= NBANKS tied 0
module ahb_gpio_bank_ctrl
    import ahb_gpio_pkg::*;
#(
    parameter int NBANKS      = 8,
    parameter int BANK_W      = 8,
    parameter int NIRQ        = 16,
    parameter int SYNC_STAGES = 2,
    parameter int BASE_BITS   = 9
) (
    input  logic                     HCLK,
    input  logic                     HRESETn,
    input  logic                     HSEL,
    input  logic [31:0]              HADDR,
    input  logic [1:0]               HTRANS,
    input  logic                     HWRITE,
    input  logic [2:0]               HSIZE,
    input  logic [31:0]              HWDATA,
    input  logic                     HREADY,
    output logic                     HREADYOUT,
    output logic [31:0]              HRDATA,
    input  logic [NBANKS*BANK_W-1:0] gpio_in,
    output logic [NBANKS*BANK_W-1:0] gpio_out,
    output logic [NBANKS*BANK_W-1:0] gpio_oeb,
    output logic [NIRQ-1:0]          user_irq
);

    localparam int OFF_BITS  = $clog2(BANK_STRIDE);
    localparam int BANK_BITS = BASE_BITS - OFF_BITS;
    localparam int CNT_W     = $clog2(SYNC_STAGES + 2);
    // Edges become visible SYNC_STAGES+1 cycles after release; blank that window
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(SYNC_STAGES + 1);

    logic                 dp_valid, dp_write, dp_word;
    logic [BANK_BITS-1:0] dp_bank;
    logic [OFF_BITS-1:0]  dp_off;
    logic [CNT_W-1:0]     blank_cnt;
    logic                 edge_en, addr_accept;
    logic [BANK_W-1:0]    bank_rd [NBANKS];
    logic [NBANKS-1:0]    bank_irq;
    logic                 unused_bus_bits;

    assign HREADYOUT       = 1'b1;
    assign addr_accept     = HSEL & HREADY & ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));
    assign edge_en         = (blank_cnt == BLANK_END);
    assign unused_bus_bits = ^{HADDR, HTRANS, HWDATA};

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_word  <= 1'b0;
            dp_bank  <= '0;
            dp_off   <= '0;
        end else begin
            dp_valid <= addr_accept;
            if (addr_accept) begin
                dp_write <= HWRITE;
                dp_word  <= (HSIZE == HSIZE_WORD);
                dp_bank  <= HADDR[BASE_BITS-1:OFF_BITS];
                dp_off   <= HADDR[OFF_BITS-1:0];
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) blank_cnt <= '0;
        else if (blank_cnt != BLANK_END) blank_cnt <= blank_cnt + CNT_W'(1);
    end

    for (genvar b = 0; b < NBANKS; b++) begin : g_bank
        logic wr_en;
        assign wr_en = dp_valid & dp_write & dp_word & (dp_bank == BANK_BITS'(b));

        gpio_bank_core #(
            .BANK_W      (BANK_W),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_core (
            .clk     (HCLK),
            .rst_n   (HRESETn),
            .pin_in  (gpio_in[b*BANK_W +: BANK_W]),
            .edge_en (edge_en),
            .wr_en   (wr_en),
            .wr_off  (dp_off),
            .wr_data (HWDATA[BANK_W-1:0]),
            .rd_off  (dp_off),
            .rd_data (bank_rd[b]),
            .pin_out (gpio_out[b*BANK_W +: BANK_W]),
            .pin_oeb (gpio_oeb[b*BANK_W +: BANK_W]),
            .irq     (bank_irq[b])
        );
    end

    // Banks at or above NBANKS match no index and read 0
    always_comb begin
        HRDATA = '0;
        if (dp_valid && !dp_write) begin
            for (int b = 0; b < NBANKS; b++) begin
                if (dp_bank == BANK_BITS'(b)) HRDATA[BANK_W-1:0] = bank_rd[b];
            end
        end
    end

    always_comb begin
        user_irq = '0;
        user_irq[NBANKS-1:0] = bank_irq;
    end

endmodule

// File: tb/tb_ahb_gpio_bank_ctrl.sv
// tb/tb_ahb_gpio_bank_ctrl.sv - randomized and directed bench for ahb_gpio_bank_ctrl
module tb_ahb_gpio_bank_ctrl;
    import ahb_gpio_pkg::*;

    localparam int NB = 8, BW = 8, NI = 16, SS = 2, PW = NB * BW;

    logic          HCLK = 1'b0, HRESETn = 1'b0, HSEL = 1'b0, HWRITE = 1'b0, HREADY = 1'b1;
    logic [31:0]   HADDR = '0, HWDATA = '0;
    logic [1:0]    HTRANS = '0;
    logic [2:0]    HSIZE = '0;
    logic          HREADYOUT;
    logic [31:0]   HRDATA;
    logic [PW-1:0] pads = '0, gpio_out, gpio_oeb;
    logic [NI-1:0] user_irq;

    always #5 HCLK = ~HCLK;

    ahb_gpio_bank_ctrl #(.NBANKS(NB), .BANK_W(BW), .NIRQ(NI), .SYNC_STAGES(SS), .BASE_BITS(9)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
        .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .gpio_in(pads), .gpio_out(gpio_out),
        .gpio_oeb(gpio_oeb), .user_irq(user_irq)
    );

    int n_checks = 0, n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: register arrays, a history of pad values seen at each edge,
    // and the pending data-phase transfer.
    logic [7:0]    m_out [NB], m_oeb [NB], m_ien [NB], m_rise [NB], m_fall [NB], m_stat [NB];
    logic [NB-1:0] m_irq;
    logic [PW-1:0] hist [$];
    int            m_edges;
    logic          m_pend = 1'b0, m_pwr = 1'b0, m_pword = 1'b0;
    logic [31:0]   m_paddr = '0;

    task automatic model_reset();
        for (int b = 0; b < NB; b++) begin
            m_out[b] = 8'h00; m_oeb[b] = 8'hFF; m_ien[b] = 8'h00;
            m_rise[b] = 8'h00; m_fall[b] = 8'h00; m_stat[b] = 8'h00;
        end
        m_irq = '0;
        hist.delete();
        for (int i = 0; i < SS + 2; i++) hist.push_back('0);
        m_edges = 0;
        m_pend  = 1'b0;
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        int b, o;
        logic [PW-1:0] v;
        b = int'(a[8:5]);
        o = int'(a[4:0]);
        v = hist[SS-1];
        if (b >= NB) return 32'h0;
        case (o)
            0:  return {24'h0, m_out[b]};
            4:  return {24'h0, m_oeb[b]};
            8:  return {24'h0, v[b*BW +: BW]};
            12: return {24'h0, m_ien[b]};
            16: return {24'h0, m_rise[b]};
            20: return {24'h0, m_fall[b]};
            24: return {24'h0, m_stat[b]};
            default: return 32'h0;
        endcase
    endfunction

    // One clock: advance the model using the inputs now on the pins, clock, then compare.
    task automatic cycle();
        logic [PW-1:0] cur, prv, e_out, e_oeb;
        logic [7:0]    wd, set, clr, cb, pb;
        logic [7:0]    n_stat [NB];
        logic [NB-1:0] n_irq;
        logic          en, wr;
        int            wb, wo;
        hist.push_front(pads);
        cur = hist[SS];
        prv = hist[SS+1];
        void'(hist.pop_back());
        en = (m_edges + 1) >= (SS + 2);
        wd = HWDATA[7:0];
        wb = int'(m_paddr[8:5]);
        wo = int'(m_paddr[4:0]);
        wr = m_pend && m_pwr && m_pword && (wb < NB);
        for (int b = 0; b < NB; b++) begin
            cb = cur[b*BW +: BW];
            pb = prv[b*BW +: BW];
            set = en ? ((cb & ~pb & m_rise[b]) | (~cb & pb & m_fall[b])) : 8'h00;
            clr = (wr && wb == b && wo == 24) ? wd : 8'h00;
            n_stat[b] = (m_stat[b] & ~clr) | set;
            n_irq[b] = |(m_stat[b] & m_ien[b]);
        end
        if (wr) begin
            case (wo)
                0:  m_out[wb]  = wd;
                4:  m_oeb[wb]  = wd;
                12: m_ien[wb]  = wd;
                16: m_rise[wb] = wd;
                20: m_fall[wb] = wd;
                default: ;
            endcase
        end
        for (int b = 0; b < NB; b++) m_stat[b] = n_stat[b];
        m_irq = n_irq;
        m_pend = HSEL && HREADY && HTRANS[1];
        if (m_pend) begin
            m_pwr = HWRITE; m_pword = (HSIZE == 3'b010); m_paddr = HADDR;
        end
        m_edges++;
        @(posedge HCLK);
        #1;
        for (int b = 0; b < NB; b++) begin
            e_out[b*BW +: BW] = m_out[b];
            e_oeb[b*BW +: BW] = m_oeb[b];
        end
        check("gpio_out", gpio_out, e_out);
        check("gpio_oeb", gpio_oeb, e_oeb);
        check("user_irq", user_irq, {{(NI-NB){1'b0}}, m_irq});
        check("hreadyout", HREADYOUT, 1'b1);
        if (m_pend && !m_pwr) check("hrdata", HRDATA, model_read(m_paddr));
    endtask

    task automatic bus(input logic [1:0] tr, input logic w, input logic [31:0] a,
                       input logic [2:0] sz, input logic [31:0] wdat);
        HSEL = (tr != HTRANS_IDLE); HTRANS = tr; HWRITE = w; HADDR = a;
        HSIZE = sz; HWDATA = wdat; HREADY = 1'b1;
        cycle();
    endtask

    task automatic idle(input logic [31:0] wdat);
        bus(HTRANS_IDLE, 1'b0, 32'h0, HSIZE_WORD, wdat);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus(HTRANS_NONSEQ, 1'b1, a, HSIZE_WORD, 32'h0);
        idle(d);
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        bus(HTRANS_NONSEQ, 1'b0, a, HSIZE_WORD, 32'h0);
        d = HRDATA;
    endtask

    task automatic do_reset(input logic [PW-1:0] pad_val);
        HRESETn = 1'b0;
        HSEL = 1'b0; HTRANS = HTRANS_IDLE; HWRITE = 1'b0; HADDR = '0; HWDATA = '0;
        pads = pad_val;
        model_reset();
        repeat (3) @(posedge HCLK);
        #1;
        check("rst_oeb", gpio_oeb, {PW{1'b1}});
        check("rst_out", gpio_out, '0);
        check("rst_irq", user_irq, '0);
        check("rst_hready", HREADYOUT, 1'b1);
        check("rst_hrdata", HRDATA, '0);
        HRESETn = 1'b1;
    endtask

    initial begin
        logic [31:0] d, a;
        logic [2:0]  sz;

        // 1. reset
        do_reset('0);
        rd(32'h04, d);                      check("t1_oeb_read", d, 32'hFF);

        // 2. back-to-back write then read of bank3 OUT
        bus(HTRANS_NONSEQ, 1'b1, 32'h60, HSIZE_WORD, 32'h0);
        bus(HTRANS_NONSEQ, 1'b0, 32'h60, HSIZE_WORD, 32'hA5);
        check("t2_gpio_out", gpio_out[31:24], 8'hA5);
        check("t2_hrdata", HRDATA, 32'h000000A5);
        idle(0);

        // 3. rising edge on bank2 pin0 -> STAT after 3 cycles, irq after 4
        wr(32'h4C, 32'h01);
        wr(32'h50, 32'h01);
        pads[16] = 1'b1;
        idle(0);
        rd(32'h58, d);                      check("t3_stat_early", d, 32'h0);
        rd(32'h58, d);                      check("t3_stat_set", d, 32'h1);
        check("t3_irq_early", user_irq[2], 1'b0);
        idle(0);                            check("t3_irq_set", user_irq[2], 1'b1);
        wr(32'h58, 32'h01);
        idle(0);                            check("t3_irq_clr", user_irq[2], 1'b0);
        rd(32'h58, d);                      check("t3_stat_clr", d, 32'h0);

        // 4. falling edge set coincides with W1C: set wins
        wr(32'h14, 32'h10);
        pads[4] = 1'b1;
        repeat (4) idle(0);
        pads[4] = 1'b0;
        idle(0);
        bus(HTRANS_NONSEQ, 1'b1, 32'h18, HSIZE_WORD, 32'h0);
        idle(32'h10);
        rd(32'h18, d);                      check("t4_set_wins", d, 32'h10);
        wr(32'h18, 32'h10);
        rd(32'h18, d);                      check("t4_w1c", d, 32'h0);

        // 6. ignored accesses
        bus(HTRANS_NONSEQ, 1'b1, 32'h00, 3'b000, 32'h0);
        idle(32'hFF);
        wr(32'h08, 32'hFF);
        wr(32'h1C, 32'hFF);
        wr(32'h100, 32'hFF);
        bus(HTRANS_BUSY, 1'b1, 32'h00, HSIZE_WORD, 32'h0);
        idle(32'h55);
        rd(32'h00, d);                      check("t6_byte_wr", d, 32'h0);
        rd(32'h08, d);                      check("t6_in_ro", d, 32'h0);
        rd(32'h1C, d);                      check("t6_rsvd", d, 32'h0);
        rd(32'h100, d);                     check("t6_bank_oob", d, 32'h0);
        rd(32'hFFFF_FE60, d);               check("t6_upper_ign", d, 32'hA5);
        bus(HTRANS_NONSEQ, 1'b0, 32'h60, 3'b000, 32'h0);
        check("t6_byte_read", HRDATA, 32'hA5);

        // random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 7) == 0) pads = {$urandom, $urandom};
            else if ($urandom_range(0, 2) == 0) pads[$urandom_range(0, PW-1)] ^= 1'b1;
            a = {($urandom_range(0, 3) == 0) ? $urandom : 32'h0};
            a[8:0] = {4'($urandom_range(0, 10)), 3'($urandom_range(0, 7)), 2'b00};
            sz = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 2)) : HSIZE_WORD;
            HSEL   = ($urandom_range(0, 9) != 0);
            HREADY = ($urandom_range(0, 9) != 0);
            HTRANS = 2'($urandom_range(0, 3));
            HWRITE = 1'($urandom_range(0, 1));
            HADDR  = a;
            HSIZE  = sz;
            HWDATA = $urandom;
            cycle();
        end

        // 5. reset blanking with all pins high through reset
        do_reset({PW{1'b1}});
        wr(32'h10, 32'hFF);
        wr(32'h0C, 32'hFF);
        repeat (4) idle(0);
        rd(32'h18, d);                      check("t5_stat_blank", d, 32'h0);
        check("t5_irq_blank", user_irq, '0);
        pads[0] = 1'b0;
        repeat (3) idle(0);
        pads[0] = 1'b1;
        repeat (3) idle(0);
        rd(32'h18, d);                      check("t5_edge_after", d, 32'h1);
        idle(0);                            check("t5_irq_after", user_irq[0], 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
